nv_nvdla_dmaif_rdreq_gen: RTL

NV_NVDLA_DMAIF_RDREQ_GEN -- requirements
Module: nv_nvdla_dmaif_rdreq_gen

---
 rtl/nv_nvdla_dmaif_rdreq_gen.sv | 132 +++++++++++++
 1 files changed

// File: rtl/nv_nvdla_dmaif_rdreq_gen.sv
// Surface read-request generator: walks a 2-D surface line by line and cuts each
// line into DMA read requests of at most MAX_REQ_ATOMS 32-byte atoms.
module nv_nvdla_dmaif_rdreq_gen #(
    parameter int NVDLA_MEM_ADDRESS_WIDTH = 64,
    parameter int MAX_REQ_ATOMS           = 8
) (
    input  logic                                  nvdla_core_clk,
    input  logic                                  nvdla_core_rst,
    input  logic                                  cmd_vld,
    output logic                                  cmd_rdy,
    input  logic [NVDLA_MEM_ADDRESS_WIDTH-1:0]    cmd_base_addr,
    input  logic [14:0]                           cmd_line_atoms,
    input  logic [12:0]                           cmd_height,
    input  logic [31:0]                           cmd_line_stride,
    output logic [NVDLA_MEM_ADDRESS_WIDTH+14:0]   dmaif_rd_req_pd,
    output logic                                  dmaif_rd_req_vld,
    input  logic                                  dmaif_rd_req_rdy,
    output logic                                  busy,
    output logic                                  done
);

    localparam int              AW          = NVDLA_MEM_ADDRESS_WIDTH;
    localparam logic [15:0]     MAX_ATOMS   = 16'(MAX_REQ_ATOMS);
    localparam logic [AW-1:0]   CHUNK_BYTES = AW'(MAX_REQ_ATOMS * 32);

    typedef enum logic {IDLE, REQ} state_t;

    state_t        state;
    logic [AW-1:0] line_addr;
    logic [AW-1:0] cur_addr;
    logic [15:0]   atoms_left;
    logic [12:0]   line_cnt;
    logic [12:0]   height_q;
    logic [14:0]   line_atoms_q;
    logic [26:0]   stride_q;

    logic [AW-1:0] stride_step;
    logic [AW-1:0] next_chunk_addr;
    logic [AW-1:0] next_line_addr;
    logic [15:0]   cmd_atoms_total;
    logic [15:0]   line_atoms_total;
    logic [15:0]   chunk_atoms_left;
    logic          more_chunks;
    logic          more_lines;
    logic          handshake;

    // Stride is only meaningful at atom granularity; its low five bits are dropped.
    logic unused_stride_lsbs;
    assign unused_stride_lsbs = ^cmd_line_stride[4:0];

    assign stride_step      = AW'({stride_q, 5'b0});
    assign next_chunk_addr  = cur_addr + CHUNK_BYTES;
    assign next_line_addr   = line_addr + stride_step;
    assign cmd_atoms_total  = {1'b0, cmd_line_atoms} + 16'd1;
    assign line_atoms_total = {1'b0, line_atoms_q} + 16'd1;
    assign chunk_atoms_left = atoms_left - MAX_ATOMS;
    assign more_chunks      = atoms_left > MAX_ATOMS;
    assign more_lines       = line_cnt != height_q;
    assign handshake        = dmaif_rd_req_vld && dmaif_rd_req_rdy;

    // Request size field (atoms minus one) for a line with `left` atoms remaining.
    function automatic logic [14:0] req_size(input logic [15:0] left);
        return (left > MAX_ATOMS) ? 15'(MAX_ATOMS - 16'd1) : 15'(left - 16'd1);
    endfunction

    // NOTE: nonblocking assignments throughout, so every branch below reads the
    // pre-edge register values regardless of statement order.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            // NOTE: datapath registers are reset too, so pd reads 0 out of reset
            // and an abandoned command leaves nothing behind.
            state            <= IDLE;
            cmd_rdy          <= 1'b1;
            busy             <= 1'b0;
            done             <= 1'b0;
            dmaif_rd_req_vld <= 1'b0;
            dmaif_rd_req_pd  <= '0;
            line_addr        <= '0;
            cur_addr         <= '0;
            atoms_left       <= '0;
            line_cnt         <= '0;
            height_q         <= '0;
            line_atoms_q     <= '0;
            stride_q         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_vld && cmd_rdy) begin
                        height_q         <= cmd_height;
                        line_atoms_q     <= cmd_line_atoms;
                        stride_q         <= cmd_line_stride[31:5];
                        line_addr        <= cmd_base_addr;
                        cur_addr         <= cmd_base_addr;
                        atoms_left       <= cmd_atoms_total;
                        line_cnt         <= '0;
                        dmaif_rd_req_pd  <= {req_size(cmd_atoms_total), cmd_base_addr};
                        dmaif_rd_req_vld <= 1'b1;
                        cmd_rdy          <= 1'b0;
                        busy             <= 1'b1;
                        state            <= REQ;
                    end
                end
                REQ: begin
                    // The next request is registered at the handshake edge, so
                    // chunks and lines follow each other with no bubble.
                    if (handshake) begin
                        if (more_chunks) begin
                            cur_addr        <= next_chunk_addr;
                            atoms_left      <= chunk_atoms_left;
                            dmaif_rd_req_pd <= {req_size(chunk_atoms_left), next_chunk_addr};
                        end else if (more_lines) begin
                            line_addr       <= next_line_addr;
                            cur_addr        <= next_line_addr;
                            atoms_left      <= line_atoms_total;
                            line_cnt        <= line_cnt + 13'd1;
                            dmaif_rd_req_pd <= {req_size(line_atoms_total), next_line_addr};
                        end else begin
                            dmaif_rd_req_vld <= 1'b0;
                            dmaif_rd_req_pd  <= '0;
                            cmd_rdy          <= 1'b1;
                            busy             <= 1'b0;
                            done             <= 1'b1;
                            state            <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
